// File: rtl/pcpu_run_ctrl.sv
// Run/debug sequencer for the 5-stage pipelined CPU: enable/start/step/resume/breakpoint -> fetch_en, pipe_en, flush.
// Optional macro PCPU_BP_EN enables PC breakpoints, the DRAIN state and the sticky bp_hit flag.
module pcpu_run_ctrl #(
    parameter int PC_W         = 8,
    parameter int CNT_W        = 16,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             start,
    input  logic             step,
    input  logic             resume,
    input  logic             halt_wb,
    input  logic [PC_W-1:0]  pc,
    input  logic             bp_valid,
    input  logic [PC_W-1:0]  bp_addr,
    output logic             fetch_en,
    output logic             pipe_en,
    output logic             flush,
    output logic [2:0]       state,
    output logic             halted,
    output logic             bp_hit,
    output logic [CNT_W-1:0] cycle_cnt
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        EXEC  = 3'd1,
        DRAIN = 3'd2,
        PAUSE = 3'd3,
        STEP  = 3'd4,
        HALT  = 3'd5
    } state_t;

    state_t           state_r;
    state_t           next_s;
    logic             fetch_en_r;
    logic             pipe_en_r;
    logic             flush_r;
    logic             halted_r;
    logic             bp_hit_r;
    logic [CNT_W-1:0] cnt_r;
    logic             from_pause_r;
    logic             launch_s;
    logic             resume_s;
    logic             bp_set_s;
    logic             bp_clr_s;
    logic             bp_match_s;
    logic             drain_done_s;

`ifdef PCPU_BP_EN
    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    logic [DW-1:0] drain_cnt_r;

    // A resume lands on the breakpoint PC, so the compare sleeps for that first cycle.
    assign bp_match_s   = bp_valid && (pc == bp_addr) && !from_pause_r;
    assign drain_done_s = (drain_cnt_r == DW'(DRAIN_CYCLES - 1));

    // Drain cycle counter, restarted on every entry into DRAIN
    always_ff @(posedge clk) begin
        if (reset) begin
            drain_cnt_r <= '0;
        end else if (state_r == DRAIN) begin
            drain_cnt_r <= drain_cnt_r + DW'(1);
        end else begin
            drain_cnt_r <= '0;
        end
    end
`else
    logic unused_s;
    assign bp_match_s   = 1'b0;
    assign drain_done_s = 1'b0;
    assign unused_s     = &{1'b0, bp_valid, bp_addr, pc, from_pause_r, drain_done_s, (DRAIN_CYCLES > 0)};
`endif

    // Next-state selection and transition events
    always_comb begin
        next_s   = state_r;
        launch_s = 1'b0;
        resume_s = 1'b0;
        bp_set_s = 1'b0;
        bp_clr_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (enable && start) begin
                    next_s   = EXEC;
                    launch_s = 1'b1;
                end else begin
                    next_s = IDLE;
                end
            end
            EXEC: begin
                if (halt_wb) begin
                    next_s = HALT;
                end else if (!enable) begin
                    next_s = PAUSE;
                end else if (bp_match_s) begin
                    next_s   = DRAIN;
                    bp_set_s = 1'b1;
                end else begin
                    next_s = EXEC;
                end
            end
`ifdef PCPU_BP_EN
            DRAIN: begin
                if (halt_wb) begin
                    next_s = HALT;
                end else if (!enable || drain_done_s) begin
                    next_s = PAUSE;
                end else begin
                    next_s = DRAIN;
                end
            end
`endif
            PAUSE: begin
                if (enable && resume) begin
                    next_s   = EXEC;
                    resume_s = 1'b1;
                    bp_clr_s = 1'b1;
                end else if (enable && step) begin
                    next_s = STEP;
                end else begin
                    next_s = PAUSE;
                end
            end
            STEP: begin
                if (halt_wb) begin
                    next_s = HALT;
                end else begin
                    next_s = PAUSE;
                end
            end
            HALT: begin
                if (enable && start) begin
                    next_s   = EXEC;
                    launch_s = 1'b1;
                    bp_clr_s = 1'b1;
                end else begin
                    next_s = HALT;
                end
            end
            default: begin
                next_s = IDLE;
            end
        endcase
    end

    // State register with outputs decoded from the next state so they align with it
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            fetch_en_r   <= 1'b0;
            pipe_en_r    <= 1'b0;
            flush_r      <= 1'b0;
            halted_r     <= 1'b0;
            bp_hit_r     <= 1'b0;
            cnt_r        <= '0;
            from_pause_r <= 1'b0;
        end else begin
            state_r      <= next_s;
            fetch_en_r   <= (next_s == EXEC) || (next_s == STEP);
            pipe_en_r    <= (next_s == EXEC) || (next_s == STEP) || (next_s == DRAIN);
            flush_r      <= launch_s;
            halted_r     <= (next_s == HALT);
            from_pause_r <= resume_s;
            if (bp_clr_s) begin
                bp_hit_r <= 1'b0;
            end else if (bp_set_s) begin
                bp_hit_r <= 1'b1;
            end else begin
                bp_hit_r <= bp_hit_r;
            end
            if (launch_s) begin
                cnt_r <= '0;
            end else if (pipe_en_r && (cnt_r != {CNT_W{1'b1}})) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign state     = state_r;
    assign fetch_en  = fetch_en_r;
    assign pipe_en   = pipe_en_r;
    assign flush     = flush_r;
    assign halted    = halted_r;
    assign bp_hit    = bp_hit_r;
    assign cycle_cnt = cnt_r;

endmodule

// File: tb/tb_pcpu_run_ctrl.sv
// Self-checking bench for pcpu_run_ctrl: vector table plus hand sequences, expectations via a scoreboard queue.
module tb_pcpu_run_ctrl;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_EXEC  = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_PAUSE = 3'd3;
    localparam logic [2:0] S_STEP  = 3'd4;
    localparam logic [2:0] S_HALT  = 3'd5;

    logic        clk = 1'b0;
    logic        reset, enable, start, step, resume, halt_wb, bp_valid;
    logic [7:0]  pc, bp_addr;
    logic        fetch_en, pipe_en, flush, halted, bp_hit;
    logic [2:0]  state;
    logic [15:0] cycle_cnt;

    pcpu_run_ctrl dut (
        .clk(clk), .reset(reset), .enable(enable), .start(start), .step(step),
        .resume(resume), .halt_wb(halt_wb), .pc(pc), .bp_valid(bp_valid),
        .bp_addr(bp_addr), .fetch_en(fetch_en), .pipe_en(pipe_en), .flush(flush),
        .state(state), .halted(halted), .bp_hit(bp_hit), .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  st;
        logic        fe, pe, fl, hl, bh;
        logic [15:0] cnt;
    } exp_t;

    typedef struct {
        logic       en, st, sp, rs, hw;
        logic [2:0] es;
        logic       ef, ep, efl, eh;
    } vec_t;

    exp_t        sb[$];
    vec_t        tbl[17];
    int          errors = 0;
    int          checks = 0;
    logic [15:0] m_cnt = 16'h0000;
    logic        m_pipe = 1'b0;
    logic [15:0] base;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    // Drive one cycle of inputs, predict outputs after the edge, then compare
    task automatic apply(input string nm, input logic en, input logic st, input logic sp,
                         input logic rs, input logic hw, input logic rst,
                         input logic [2:0] es, input logic ef, input logic ep,
                         input logic efl, input logic eh, input logic eb);
        exp_t e;
        enable = en; start = st; step = sp; resume = rs; halt_wb = hw; reset = rst;
        if (rst || efl) m_cnt = 16'h0000;
        else if (m_pipe && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'h0001;
        m_pipe = rst ? 1'b0 : ep;
        e.name = nm; e.st = es; e.fe = ef; e.pe = ep; e.fl = efl; e.hl = eh; e.bh = eb; e.cnt = m_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.name, ".state"},     {29'd0, state},     {29'd0, e.st});
        chk({e.name, ".fetch_en"},  {31'd0, fetch_en},  {31'd0, e.fe});
        chk({e.name, ".pipe_en"},   {31'd0, pipe_en},   {31'd0, e.pe});
        chk({e.name, ".flush"},     {31'd0, flush},     {31'd0, e.fl});
        chk({e.name, ".halted"},    {31'd0, halted},    {31'd0, e.hl});
        chk({e.name, ".bp_hit"},    {31'd0, bp_hit},    {31'd0, e.bh});
        chk({e.name, ".cycle_cnt"}, {16'd0, cycle_cnt}, {16'd0, e.cnt});
    endtask

    task automatic run(input string nm, input logic eb);
        apply(nm, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_EXEC, 1'b1, 1'b1, 1'b0, 1'b0, eb);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; start = 1'b0; step = 1'b0; resume = 1'b0;
        halt_wb = 1'b0; bp_valid = 1'b0; pc = 8'h00; bp_addr = 8'h05;

        //          en    st    sp    rs    hw    state    fe    pe    fl    hl
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, S_IDLE,  1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE,  1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, S_EXEC,  1'b1, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_EXEC,  1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, S_EXEC,  1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_PAUSE, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, S_PAUSE, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, S_STEP,  1'b1, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_PAUSE, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, S_EXEC,  1'b1, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, S_HALT,  1'b0, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_HALT,  1'b0, 1'b0, 1'b0, 1'b1};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, S_EXEC,  1'b1, 1'b1, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_PAUSE, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, S_STEP,  1'b1, 1'b1, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, S_HALT,  1'b0, 1'b0, 1'b0, 1'b1};
        tbl[16] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, S_EXEC,  1'b1, 1'b1, 1'b1, 1'b0};

        apply("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 17; i++) begin
            apply($sformatf("vec%0d", i), tbl[i].en, tbl[i].st, tbl[i].sp, tbl[i].rs, tbl[i].hw,
                  1'b0, tbl[i].es, tbl[i].ef, tbl[i].ep, tbl[i].efl, tbl[i].eh, 1'b0);
        end

        for (int i = 0; i < 10; i++) run("run10", 1'b0);
        chk("cnt_after_10", {16'd0, cycle_cnt}, 32'd10);

`ifdef PCPU_BP_EN
        bp_valid = 1'b1; pc = 8'h05;
        apply("bp_enter", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_DRAIN, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        pc = 8'h06;
        for (int i = 0; i < 3; i++)
            apply("drain", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_DRAIN, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        apply("drain_end", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_PAUSE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        pc = 8'h05;
        apply("bp_resume", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, S_EXEC, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        run("no_retrig", 1'b0);
        pc = 8'h06;
        run("past_bp", 1'b0);
`else
        bp_valid = 1'b1; pc = 8'h05;
        run("bp_off_1", 1'b0);
        run("bp_off_2", 1'b0);
`endif
        bp_valid = 1'b0;

        apply("to_pause", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_PAUSE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        base = m_cnt;
        for (int i = 0; i < 3; i++) begin
            apply("step", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, S_STEP, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            apply("step_back", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_PAUSE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk("step_cnt_plus3", {16'd0, cycle_cnt}, {16'd0, base + 16'd3});

        apply("resume", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, S_EXEC, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        apply("halt", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, S_HALT, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        apply("halt_hold", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_HALT, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        apply("halt_hold", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_HALT, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        apply("restart", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_EXEC, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("restart_cnt0", {16'd0, cycle_cnt}, 32'd0);

        bp_valid = 1'b1; pc = 8'h05;
        apply("halt_vs_bp", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, S_HALT, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        bp_valid = 1'b0;
        apply("restart2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_EXEC, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        run("run", 1'b0);
        apply("en_drop", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_PAUSE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        apply("resume2", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, S_EXEC, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        run("run", 1'b0);
`ifdef PCPU_BP_EN
        bp_valid = 1'b1; pc = 8'h05;
        apply("bp_enter2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_DRAIN, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        apply("drain2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_DRAIN, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        bp_valid = 1'b0;
`endif
        apply("reset_mid", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        apply("sat_start", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_EXEC, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 65537; i++) run("sat_run", 1'b0);
        chk("cnt_saturated", {16'd0, cycle_cnt}, 32'h0000FFFF);
        for (int i = 0; i < 3; i++) run("sat_hold", 1'b0);
        chk("cnt_stays_ffff", {16'd0, cycle_cnt}, 32'h0000FFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pcpu_run_ctrl.md
Name: pcpu_run_ctrl

Overview:
- Run/debug sequencer for the 5-stage pipelined CPU.
- Turns enable/start/step/resume and a PC breakpoint into per-cycle pipeline controls: fetch_en, pipe_en, flush.
- Detects HALT retiring in WB; counts executed cycles.
- Sits between the board/test controls and the CPU core; replaces the core's internal idle/exec flag.

Parameters:
- PC_W, 8: width of pc and bp_addr.
- CNT_W, 16: width of cycle_cnt.
- DRAIN_CYCLES, 4: cycles the pipeline keeps running after fetch stops on a breakpoint (ID, EX, MEM, WB).

Ports:
- clk, in, 1: system clock; all logic is on the rising edge.
- reset, in, 1: synchronous, active-high; takes effect on the next rising clk edge.
- enable, in, 1: run permission; low freezes the pipeline.
- start, in, 1: level-sampled start/restart request.
- step, in, 1: single-cycle advance request while paused.
- resume, in, 1: return from PAUSE to EXEC.
- halt_wb, in, 1: opcode in WB is HALT (5'b00001).
- pc, in, PC_W: current fetch PC.
- bp_valid, in, 1: breakpoint armed.
- bp_addr, in, PC_W: breakpoint PC.
- fetch_en, out, 1: IF may advance the PC and load the instruction register.
- pipe_en, out, 1: ID/EX/MEM/WB registers may advance.
- flush, out, 1: clear pc to 0 and all stage IRs to NOP.
- state, out, 3: IDLE=0, EXEC=1, DRAIN=2, PAUSE=3, STEP=4, HALT=5.
- halted, out, 1: state==HALT.
- bp_hit, out, 1: sticky breakpoint-taken flag.
- cycle_cnt, out, CNT_W: number of cycles with pipe_en=1.

Behaviour:
- All outputs are registered and decoded from state, except flush, which is a registered one-cycle pulse.
- Reset values: state=IDLE, fetch_en=0, pipe_en=0, flush=0, halted=0, bp_hit=0, cycle_cnt=0. Reset mid-operation returns to IDLE on the next edge regardless of state.
- Output decode by state:
  - EXEC: fetch_en=1, pipe_en=1.
  - STEP: fetch_en=1, pipe_en=1.
  - DRAIN: fetch_en=0, pipe_en=1.
  - IDLE, PAUSE, HALT: both 0.
- IDLE: enable&start moves to EXEC. flush=1 during the first EXEC cycle only. cycle_cnt is cleared on that same transition.
- EXEC, transition priority:
  1. halt_wb goes to HALT.
  2. !enable goes to PAUSE.
  3. bp_valid & pc==bp_addr goes to DRAIN and sets bp_hit.
  4. Otherwise stay in EXEC.
  - Start is ignored in EXEC.
  - Breakpoint compare is suppressed in the first EXEC cycle after entry from PAUSE, so a resume does not re-trigger on the same PC.
- DRAIN: an internal counter runs for DRAIN_CYCLES cycles, then the block goes to PAUSE.
  - halt_wb during DRAIN goes to HALT.
  - !enable goes to PAUSE early; the counter is discarded.
- PAUSE:
  - enable&resume goes to EXEC and clears bp_hit.
  - Otherwise enable&step goes to STEP.
  - resume has priority over step.
- STEP: exactly one cycle, then back to PAUSE. If halt_wb is sampled in STEP, go to HALT instead.
- HALT: enable&start goes to EXEC with a flush pulse, cycle_cnt cleared and bp_hit cleared. Otherwise stay in HALT.
- cycle_cnt increments on every cycle whose registered pipe_en=1.
  - Saturates at all-ones; no wrap.
  - Holds in IDLE, PAUSE and HALT.
- Simultaneous events:
  - halt_wb and breakpoint in the same cycle: HALT wins, bp_hit is not set.
  - step and !enable: ignored.
- Unused state encodings (6, 7) go to IDLE on the next edge.

Optional Feature:
- PCPU_BP_EN defined: breakpoint logic, the DRAIN state and bp_hit behave as above.
- Undefined: bp_valid and bp_addr are ignored, DRAIN is unreachable, bp_hit is tied to 0, and the DRAIN counter is not synthesised. All other behaviour is unchanged.

Test Plan:
- Reset, enable=1, pulse start.
  - Expected: the next cycle has state=1, flush=1 (one cycle only), fetch_en=pipe_en=1.
  - After 10 cycles, cycle_cnt=10.
- In EXEC, with bp_valid=1 and bp_addr=8'h05, pc reaches 8'h05.
  - Expected: state=2 with fetch_en=0, pipe_en=1 for exactly 4 cycles, then state=3, bp_hit=1.
  - Pulse resume: state=1, bp_hit=0, no re-trigger at pc 8'h05.
- In PAUSE, pulse step 3 times.
  - Expected: each pulse gives exactly one cycle of state=4 with fetch_en=pipe_en=1.
  - cycle_cnt increases by 3.
- Raise halt_wb in EXEC.
  - Expected: state=5, halted=1, pipe_en=0, cycle_cnt frozen.
  - Then pulse start: state=1, flush=1, cycle_cnt=0.
- Drop enable mid-EXEC.
  - Expected: state=3 on the next edge, fetch_en=pipe_en=0.
  - Assert reset while in DRAIN: every output returns to its reset value on the next edge.
- Force cycle_cnt to 16'hFFFE and run 3 cycles.
  - Expected: cycle_cnt stays at 16'hFFFF.
  - With PCPU_BP_EN undefined, a PC match leaves state=1 and bp_hit=0.
